// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared widths, counter types and the accumulator width helper
package dotprod_pkg;

    localparam int PROD_W   = 32;
    localparam int MATRIX_N = 3;

    function automatic int acc_width(input int prod_w, input int n);
        return prod_w + $clog2(n);
    endfunction

    localparam int ACC_W = acc_width(PROD_W, MATRIX_N);
    localparam int CNT_W = (MATRIX_N > 1) ? $clog2(MATRIX_N) : 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [3:0]       elem_idx_t;

    localparam cnt_t      CNT_LAST = cnt_t'(MATRIX_N - 1);
    localparam elem_idx_t IDX_LAST = elem_idx_t'(MATRIX_N * MATRIX_N - 1);

endpackage

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator: sums MATRIX_N products per group, registered SUM out; DOT_ELEM_INDEX_EN adds ELEM_IDX
module dot_product_accumulator
    import dotprod_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] PROD,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [ACC_W-1:0]  SUM
`ifdef DOT_ELEM_INDEX_EN
    ,
    output elem_idx_t         ELEM_IDX
`endif
);

    cnt_t             cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic [ACC_W-1:0] prod_ext, acc_next;
    logic             last, in_fire, out_fire;

    assign prod_ext   = {{(ACC_W-PROD_W){1'b0}}, PROD};
    assign last       = (cnt_q == CNT_LAST);
    assign prod_ready = !flush && !(last && sum_valid_q && !sum_ready);
    assign in_fire    = prod_valid && prod_ready;
    assign out_fire   = sum_valid_q && sum_ready;
    assign acc_next   = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
    assign SUM        = sum_q;
    assign sum_valid  = sum_valid_q;

    // Next-state: term counter and accumulator (flush wins), output register load/drain
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        if (flush) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (in_fire) begin
            acc_d = acc_next;
            cnt_d = last ? '0 : cnt_q + cnt_t'(1);
        end
        if (in_fire && last) begin
            sum_d       = acc_next;
            sum_valid_d = 1'b1;
        end else if (out_fire) begin
            sum_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

`ifdef DOT_ELEM_INDEX_EN
    elem_idx_t idx_q, idx_d;

    assign ELEM_IDX = idx_q;

    // Row-major element index advances with each consumed result
    always_comb begin
        idx_d = out_fire ? ((idx_q == IDX_LAST) ? '0 : idx_q + elem_idx_t'(1)) : idx_q;
    end

    // Element index register
    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end
`endif

endmodule
